chromakey_ctrl: RTL and testbench



---
 rtl/chromakey_ctrl_if.sv | 15 +
 rtl/chromakey_ctrl.sv | 159 +++++++++++++++
 tb/tb_chromakey_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chromakey_ctrl_if.sv
// Host configuration write port of the chromakey controller.
//
// Handshake: a write transfers on a rising clock edge where cfg_wr and
// cfg_ready are both high. cfg_ready is driven only by the controller.
// While cfg_ready is low the host keeps cfg_wr, cfg_addr and cfg_wdata
// stable until a transfer edge occurs.
interface chromakey_ctrl_if;
  logic       cfg_wr;
  logic [1:0] cfg_addr;   // 0 = G_MIN, 1 = DR, 2 = DB, 3 = SATMIN
  logic [5:0] cfg_wdata;
  logic       cfg_ready;

  modport master (output cfg_wr, output cfg_addr, output cfg_wdata, input cfg_ready);
  modport slave  (input cfg_wr, input cfg_addr, input cfg_wdata, output cfg_ready);
endinterface

// File: rtl/chromakey_ctrl.sv
// Chromakey configuration and statistics controller.
// Host writes land in staging registers. They reach the classifier only
// in the APPLY cycle that follows a frame_start, so a frame never sees a
// mix of two threshold sets. Background pixels are counted per frame, and
// the completed count is reported once per frame.
module chromakey_ctrl #(
  parameter logic [5:0] G_MIN_RST  = 6'd12,
  parameter logic [5:0] DR_RST     = 6'd3,
  parameter logic [5:0] DB_RST     = 6'd2,
  parameter logic [5:0] SATMIN_RST = 6'd6,
  parameter int         CNT_W      = 19
) (
  input  logic               clk,
  input  logic               reset,
  chromakey_ctrl_if.slave    cfg,
  input  logic               frame_start,
  input  logic               DE,
  input  logic               bg_pixel,
  output logic [5:0]         g_min,
  output logic [5:0]         dr,
  output logic [5:0]         db,
  output logic [5:0]         satmin,
  output logic               cfg_pending,
  output logic [CNT_W-1:0]   bg_count,
  output logic               stat_valid,
  output logic               cnt_sat,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_cfg_ready;
  logic             r_cfg_pending;
  logic             r_late_wr;
  logic [5:0]       r_stg_g_min, r_stg_dr, r_stg_db, r_stg_satmin;
  logic [5:0]       r_g_min, r_dr, r_db, r_satmin;
  logic [CNT_W-1:0] r_acc;
  logic             r_sat;
  logic [CNT_W-1:0] r_bg_count;
  logic             r_cnt_sat;
  logic             r_stat_valid;

  logic             w_wr_acc;
  logic             w_inc;
  logic             w_acc_at_max;
  logic [CNT_W-1:0] w_acc_plus;
  logic             w_sat_drop;
  logic             w_report;

  assign w_wr_acc     = cfg.cfg_wr & r_cfg_ready;
  assign w_inc        = DE & bg_pixel;
  assign w_acc_at_max = (r_acc == CNT_MAX);
  // Saturating increment: a bg pixel seen at the maximum is dropped and flagged.
  assign w_acc_plus   = (w_inc && !w_acc_at_max) ? (r_acc + CNT_ONE) : r_acc;
  assign w_sat_drop   = w_inc & w_acc_at_max;
  // Reports happen on every frame_start except the first one out of IDLE.
  assign w_report     = frame_start & (r_state != S_IDLE);

  // Staging registers take every accepted host write; the last write wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stg_g_min  <= G_MIN_RST;
      r_stg_dr     <= DR_RST;
      r_stg_db     <= DB_RST;
      r_stg_satmin <= SATMIN_RST;
    end else if (w_wr_acc) begin
      case (cfg.cfg_addr)
        2'd0:    r_stg_g_min  <= cfg.cfg_wdata;
        2'd1:    r_stg_dr     <= cfg.cfg_wdata;
        2'd2:    r_stg_db     <= cfg.cfg_wdata;
        default: r_stg_satmin <= cfg.cfg_wdata;
      endcase
    end
  end

  // Control FSM: frame sequencing, the apply step, pending flag and write ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cfg_ready   <= 1'b1;
      r_cfg_pending <= 1'b0;
      r_late_wr     <= 1'b0;
      r_g_min       <= G_MIN_RST;
      r_dr          <= DR_RST;
      r_db          <= DB_RST;
      r_satmin      <= SATMIN_RST;
    end else begin
      if (w_wr_acc) r_cfg_pending <= 1'b1;
      case (r_state)
        S_IDLE, S_RUN: begin
          // A write that coincides with the frame_start that launches APPLY
          // keeps the pending flag alive through that APPLY.
          r_late_wr <= w_wr_acc & frame_start & r_cfg_pending;
          if (frame_start) begin
            r_state     <= r_cfg_pending ? S_APPLY : S_RUN;
            r_cfg_ready <= ~r_cfg_pending;
          end
        end
        S_APPLY: begin
          r_g_min       <= r_stg_g_min;
          r_dr          <= r_stg_dr;
          r_db          <= r_stg_db;
          r_satmin      <= r_stg_satmin;
          r_cfg_pending <= r_late_wr;
          r_late_wr     <= 1'b0;
          r_state       <= S_RUN;
          r_cfg_ready   <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Per-frame bg pixel accumulator and the report of the completed frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_sat        <= 1'b0;
      r_bg_count   <= '0;
      r_cnt_sat    <= 1'b0;
      r_stat_valid <= 1'b0;
    end else begin
      r_stat_valid <= w_report;
      if (w_report) begin
        // The pixel on the frame_start cycle still belongs to the ending frame.
        r_bg_count <= w_acc_plus;
        r_cnt_sat  <= r_sat | w_sat_drop;
        r_acc      <= '0;
        r_sat      <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_acc <= w_acc_plus;
        r_sat <= r_sat | w_sat_drop;
      end
    end
  end

  assign cfg.cfg_ready = r_cfg_ready;
  assign g_min         = r_g_min;
  assign dr            = r_dr;
  assign db            = r_db;
  assign satmin        = r_satmin;
  assign cfg_pending   = r_cfg_pending;
  assign bg_count      = r_bg_count;
  assign stat_valid    = r_stat_valid;
  assign cnt_sat       = r_cnt_sat;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_chromakey_ctrl.sv
// Bench for chromakey_ctrl: a full-width instance and a 4-bit-counter
// instance see the same frame/pixel stream; only the full-width one gets
// host writes. Frame reports are checked through an expected queue.
module tb_chromakey_ctrl;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  logic clk = 1'b0;
  logic reset;
  logic frame_start, de, bg_pixel;

  chromakey_ctrl_if cfg ();
  chromakey_ctrl_if cfg_s ();

  logic [5:0]  g_min, dr, db, satmin;
  logic        cfg_pending, stat_valid, cnt_sat;
  logic [18:0] bg_count;
  logic [1:0]  dbg_state;

  logic [5:0]  s_g_min, s_dr, s_db, s_satmin;
  logic        s_cfg_pending, s_stat_valid, s_cnt_sat;
  logic [3:0]  s_bg_count;
  logic [1:0]  s_dbg_state;

  chromakey_ctrl u_dut (
    .clk(clk), .reset(reset), .cfg(cfg.slave),
    .frame_start(frame_start), .DE(de), .bg_pixel(bg_pixel),
    .g_min(g_min), .dr(dr), .db(db), .satmin(satmin),
    .cfg_pending(cfg_pending), .bg_count(bg_count),
    .stat_valid(stat_valid), .cnt_sat(cnt_sat), .dbg_state(dbg_state)
  );

  chromakey_ctrl #(.CNT_W(4)) u_small (
    .clk(clk), .reset(reset), .cfg(cfg_s.slave),
    .frame_start(frame_start), .DE(de), .bg_pixel(bg_pixel),
    .g_min(s_g_min), .dr(s_dr), .db(s_db), .satmin(s_satmin),
    .cfg_pending(s_cfg_pending), .bg_count(s_bg_count),
    .stat_valid(s_stat_valid), .cnt_sat(s_cnt_sat), .dbg_state(s_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int stat_seen = 0;
  int stat_exp  = 0;
  // {sat19, cnt19[18:0], sat4, cnt4[3:0]}
  logic [24:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [24:0] mk(input int n);
    logic [18:0] c19;
    logic [3:0]  c4;
    c19 = n[18:0];
    c4  = (n > 15) ? 4'd15 : n[3:0];
    return {1'b0, c19, (n > 15), c4};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (stat_valid) begin
      logic [24:0] e;
      stat_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_stat_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("bg_count",       {13'd0, bg_count}, {13'd0, e[23:5]});
        chk("cnt_sat",        {31'd0, cnt_sat},  {31'd0, e[24]});
        chk("small_valid",    {31'd0, s_stat_valid}, 32'd1);
        chk("small_bg_count", {28'd0, s_bg_count}, {28'd0, e[3:0]});
        chk("small_cnt_sat",  {31'd0, s_cnt_sat},  {31'd0, e[4]});
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [5:0] d);
    bit done = 1'b0;
    cfg.cfg_wr    = 1'b1;
    cfg.cfg_addr  = a;
    cfg.cfg_wdata = d;
    for (int k = 0; k < 8 && !done; k++) begin
      done = cfg.cfg_ready;
      step();
    end
    if (!done) chk("cfg_write_timeout", 32'd1, 32'd0);
    cfg.cfg_wr = 1'b0;
  endtask

  // Active-video run with exactly n_bg bg pixels among n_de DE cycles;
  // occasional blanking cycles carry bg_pixel=1 that must not count.
  task automatic pixels(input int n_de, input int n_bg);
    int rem_de = n_de;
    int rem_bg = n_bg;
    while (rem_de > 0) begin
      if ($urandom_range(0, 7) == 0) begin
        de = 1'b0;
        bg_pixel = 1'b1;
      end else begin
        de = 1'b1;
        bg_pixel = ($urandom_range(0, rem_de - 1) < rem_bg);
        if (bg_pixel) rem_bg--;
        rem_de--;
      end
      step();
    end
    de = 1'b0;
    bg_pixel = 1'b0;
    step();
  endtask

  task automatic frame_pulse(input bit push, input logic [24:0] e);
    if (push) begin
      exp_q.push_back(e);
      stat_exp++;
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int   n_de;
    int   n_bg;
    int   exp_cnt;
    int   exp_cnt4;
    bit   exp_sat4;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1000, 437, 437, 15, 1'b1};
    tbl[1] = '{50,   20,  20,  15, 1'b1};
    tbl[2] = '{40,   3,   3,   3,  1'b0};
    tbl[3] = '{30,   15,  15,  15, 1'b0};
    tbl[4] = '{30,   16,  16,  15, 1'b1};
    tbl[5] = '{10,   0,   0,   0,  1'b0};

    frame_start = 1'b0; de = 1'b0; bg_pixel = 1'b0;
    cfg.cfg_wr = 1'b0; cfg.cfg_addr = 2'd0; cfg.cfg_wdata = 6'd0;
    cfg_s.cfg_wr = 1'b0; cfg_s.cfg_addr = 2'd0; cfg_s.cfg_wdata = 6'd0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_g_min", {26'd0, g_min}, 32'd12);
    chk("rst_dr", {26'd0, dr}, 32'd3);
    chk("rst_db", {26'd0, db}, 32'd2);
    chk("rst_satmin", {26'd0, satmin}, 32'd6);
    chk("rst_ready", {31'd0, cfg.cfg_ready}, 32'd1);
    chk("rst_pending", {31'd0, cfg_pending}, 32'd0);
    chk("rst_bg_count", {13'd0, bg_count}, 32'd0);
    chk("rst_cnt_sat", {31'd0, cnt_sat}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("rst_small_count", {28'd0, s_bg_count}, 32'd0);
    step();

    // Pixels in IDLE are ignored; first frame_start gives no report.
    pixels(20, 9);
    frame_pulse(1'b0, '0);
    step(); step();
    chk("first_frame_no_stat", stat_seen, 32'd0);
    chk("state_run", {30'd0, dbg_state}, {30'd0, ST_RUN});

    // Mid-frame writes, then apply at the frame boundary.
    pixels(500, 200);
    cfg_write(2'd0, 6'd20);
    cfg_write(2'd3, 6'd9);
    chk("pending_set", {31'd0, cfg_pending}, 32'd1);
    chk("g_min_held", {26'd0, g_min}, 32'd12);
    pixels(500, 237);
    frame_pulse(1'b1, {1'b0, 19'd437, 1'b1, 4'd15});
    @(negedge clk);
    chk("apply_ready_low", {31'd0, cfg.cfg_ready}, 32'd0);
    chk("apply_state", {30'd0, dbg_state}, {30'd0, ST_APPLY});
    chk("apply_g_min_old", {26'd0, g_min}, 32'd12);
    @(negedge clk);
    chk("applied_g_min", {26'd0, g_min}, 32'd20);
    chk("applied_satmin", {26'd0, satmin}, 32'd9);
    chk("applied_dr", {26'd0, dr}, 32'd3);
    chk("applied_db", {26'd0, db}, 32'd2);
    chk("applied_pending", {31'd0, cfg_pending}, 32'd0);
    chk("applied_ready", {31'd0, cfg.cfg_ready}, 32'd1);
    step();

    // Table-driven frames (first frame's pixels were driven above).
    for (int i = 1; i < 6; i++) begin
      pixels(tbl[i].n_de, tbl[i].n_bg);
      frame_pulse(1'b1, {1'b0, tbl[i].exp_cnt[18:0], tbl[i].exp_sat4, tbl[i].exp_cnt4[3:0]});
    end
    step();

    // Write coincident with frame_start while nothing pending.
    exp_q.push_back(mk(0));
    stat_exp++;
    frame_start = 1'b1;
    cfg.cfg_wr = 1'b1; cfg.cfg_addr = 2'd1; cfg.cfg_wdata = 6'd5;
    step();
    frame_start = 1'b0;
    cfg.cfg_wr = 1'b0;
    @(negedge clk);
    chk("coinc_dr_held", {26'd0, dr}, 32'd3);
    chk("coinc_pending", {31'd0, cfg_pending}, 32'd1);
    chk("coinc_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
    step();
    pixels(20, 7);
    frame_pulse(1'b1, mk(7));
    @(negedge clk);
    @(negedge clk);
    chk("coinc_dr_applied", {26'd0, dr}, 32'd5);
    step();

    // Back-to-back frame_start, second one landing in APPLY.
    cfg_write(2'd0, 6'd33);
    pixels(8, 5);
    exp_q.push_back(mk(5));
    exp_q.push_back(mk(0));
    stat_exp += 2;
    frame_start = 1'b1;
    step();
    step();
    frame_start = 1'b0;
    @(negedge clk);
    chk("b2b_g_min", {26'd0, g_min}, 32'd33);
    chk("b2b_pending", {31'd0, cfg_pending}, 32'd0);
    chk("b2b_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
    step();

    // Reset during APPLY drops the staged write.
    cfg_write(2'd2, 6'd30);
    pixels(12, 4);
    frame_pulse(1'b1, mk(4));
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rstapply_db", {26'd0, db}, 32'd2);
    chk("rstapply_pending", {31'd0, cfg_pending}, 32'd0);
    chk("rstapply_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("rstapply_ready", {31'd0, cfg.cfg_ready}, 32'd1);
    chk("rstapply_bg_count", {13'd0, bg_count}, 32'd0);
    step();
    frame_pulse(1'b0, '0);
    @(negedge clk);
    chk("rstapply_db_after_frame", {26'd0, db}, 32'd2);
    step();
    pixels(10, 6);
    frame_pulse(1'b1, mk(6));
    step(); step(); step();

    chk("reports_seen", stat_seen, stat_exp);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
